frame_buffer_sequencer: RTL and testbench

- Parametrised successor to the top-level ping-pong capture/display FSM.
- Manages NUM_BUFS camera frame buffers: selects the write buffer, gates capture write-enable, and optionally hands each captured frame to a processing block (filter) via start/done/ack.
- Commits the finished frame to the display only at display vertical blank.
- Sits between ov7670 capture, the frame-buffer BRAM muxes, the filter block and the DTG/colorizer.

---
 rtl/frame_seq_pkg.sv | 41 ++++
 rtl/vsync_edge_sync.sv | 31 +++
 rtl/frame_buffer_sequencer.sv | 142 ++++++++++++++
 tb/tb_frame_buffer_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame buffer sequencer: capture modes, FSM states
// and the free-buffer selection helper.
package frame_seq_pkg;

   localparam logic [1:0] MODE_CONT        = 2'd0;
   localparam logic [1:0] MODE_SINGLE      = 2'd1;
   localparam logic [1:0] MODE_CONT_PROC   = 2'd2;
   localparam logic [1:0] MODE_SINGLE_PROC = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_PROC    = 3'd3,
      ST_COMMIT  = 3'd4
   } seq_state_t;

   function automatic logic mode_is_cont(input logic [1:0] m);
      return (m == MODE_CONT) || (m == MODE_CONT_PROC);
   endfunction

   function automatic logic mode_is_single(input logic [1:0] m);
      return (m == MODE_SINGLE) || (m == MODE_SINGLE_PROC);
   endfunction

   function automatic logic mode_is_proc(input logic [1:0] m);
      return (m == MODE_CONT_PROC) || (m == MODE_SINGLE_PROC);
   endfunction

   // Lowest buffer index owned by neither the display nor the pending frame; -1 if none.
   function automatic int next_free_buf(input int num_bufs, input int disp_idx,
                                        input logic pend_valid, input int pend_idx);
      int found;
      found = -1;
      for (int i = num_bufs - 1; i >= 0; i--) begin
         if (i != disp_idx && !(pend_valid && i == pend_idx)) found = i;
      end
      return found;
   endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Two-flop synchronizer for an asynchronous VSYNC with registered rise/fall pulses.
// Pulses appear three clk edges after the input changes.
module vsync_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic vs_async,
   output logic vs_rise,
   output logic vs_fall
);

   logic vs_meta;
   logic vs_sync;
   logic vs_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vs_meta <= 1'b0;
         vs_sync <= 1'b0;
         vs_prev <= 1'b0;
         vs_rise <= 1'b0;
         vs_fall <= 1'b0;
      end else begin
         vs_meta <= vs_async;
         vs_sync <= vs_meta;
         vs_prev <= vs_sync;
         vs_rise <= vs_sync & ~vs_prev;
         vs_fall <= ~vs_sync & vs_prev;
      end
   end

endmodule

// File: rtl/frame_buffer_sequencer.sv
// Multi-buffer capture/process/display sequencer: picks the write buffer, gates
// capture, hands frames to the filter and swaps the display buffer at vblank.
module frame_buffer_sequencer
   import frame_seq_pkg::*;
#(
   parameter int NUM_BUFS    = 3,
   parameter int SEL_W       = 2,
   parameter int TIMEOUT_CYC = 2000000,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             trigger,
   input  logic             cam_vs,
   input  logic             disp_vblank,
   input  logic             proc_done,
   output logic             cap_en,
   output logic [SEL_W-1:0] wr_buf_sel,
   output logic [SEL_W-1:0] disp_buf_sel,
   output logic             proc_start,
   output logic [SEL_W-1:0] proc_buf_sel,
   output logic             proc_ack,
   output logic [CNT_W-1:0] frame_count,
   output logic [7:0]       drop_count,
   output logic             timeout_err,
   output logic             busy,
   output logic [2:0]       state_dbg
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   seq_state_t       state;
   logic [SEL_W-1:0] pend_idx;
   logic             pend_valid;
   logic [1:0]       mode_q;
   logic [TMO_W-1:0] tmo_cnt;
   logic             cap_en_q;
   logic             vs_rise;
   logic             vs_fall;
   int               free_idx;
   logic             free_ok;
   logic [SEL_W-1:0] free_sel;

   vsync_edge_sync u_vs_sync (
      .clk      (clk),
      .reset    (reset),
      .vs_async (cam_vs),
      .vs_rise  (vs_rise),
      .vs_fall  (vs_fall)
   );

   always_comb begin
      free_idx = next_free_buf(NUM_BUFS, int'(disp_buf_sel), pend_valid, int'(pend_idx));
      free_ok  = (free_idx >= 0);
      free_sel = free_idx[SEL_W-1:0];
   end

   // The write gate closes in the very cycle the frame-end pulse is seen.
   assign cap_en    = cap_en_q & ~vs_rise;
   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   // Display swap and the sequencing FSM share one block; a COMMIT coinciding
   // with vblank swaps in the old pending frame and keeps the new one pending.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         disp_buf_sel <= '0;
         wr_buf_sel   <= SEL_W'(1);
         proc_buf_sel <= '0;
         pend_idx     <= '0;
         pend_valid   <= 1'b0;
         mode_q       <= MODE_CONT;
         tmo_cnt      <= '0;
         cap_en_q     <= 1'b0;
         proc_start   <= 1'b0;
         proc_ack     <= 1'b0;
         frame_count  <= '0;
         drop_count   <= '0;
         timeout_err  <= 1'b0;
      end else begin
         proc_ack <= 1'b0;
         if (trigger) timeout_err <= 1'b0;
         if (disp_vblank && pend_valid) begin
            disp_buf_sel <= pend_idx;
            pend_valid   <= 1'b0;
            frame_count  <= frame_count + CNT_W'(1);
         end
         case (state)
            ST_IDLE: begin
               if (mode_is_cont(mode) || (mode_is_single(mode) && trigger)) state <= ST_ARM;
            end
            ST_ARM: begin
               mode_q <= mode;
               if (free_ok) begin
                  wr_buf_sel <= free_sel;
                  if (vs_fall) begin
                     state    <= ST_CAPTURE;
                     cap_en_q <= 1'b1;
                     tmo_cnt  <= '0;
                  end
               end
            end
            ST_CAPTURE: begin
               if (vs_rise) begin
                  cap_en_q <= 1'b0;
                  if (mode_is_proc(mode_q)) begin
                     state        <= ST_PROC;
                     proc_start   <= 1'b1;
                     proc_buf_sel <= wr_buf_sel;
                  end else begin
                     state <= ST_COMMIT;
                  end
               end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                  timeout_err <= 1'b1;
                  cap_en_q    <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            ST_PROC: begin
               if (proc_done) begin
                  proc_start <= 1'b0;
                  proc_ack   <= 1'b1;
                  state      <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               if (pend_valid && !disp_vblank && drop_count != 8'hFF)
                  drop_count <= drop_count + 8'd1;
               pend_idx   <= wr_buf_sel;
               pend_valid <= 1'b1;
               state      <= mode_is_cont(mode_q) ? ST_ARM : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_buffer_sequencer.sv
// Directed bench for frame_buffer_sequencer with three buffers and a short timeout.
module tb_frame_buffer_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] mode;
   logic       trigger;
   logic       cam_vs;
   logic       disp_vblank;
   logic       proc_done;
   logic       cap_en;
   logic [1:0] wr_buf_sel;
   logic [1:0] disp_buf_sel;
   logic       proc_start;
   logic [1:0] proc_buf_sel;
   logic       proc_ack;
   logic [15:0] frame_count;
   logic [7:0] drop_count;
   logic       timeout_err;
   logic       busy;
   logic [2:0] state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       vb;
      logic [1:0] exp_wr;
      logic [1:0] exp_disp;
      int         exp_fc;
      int         exp_dc;
   } frame_vec_t;

   frame_vec_t vecs[7];

   frame_buffer_sequencer #(
      .NUM_BUFS    (3),
      .SEL_W       (2),
      .TIMEOUT_CYC (1000),
      .CNT_W       (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .mode         (mode),
      .trigger      (trigger),
      .cam_vs       (cam_vs),
      .disp_vblank  (disp_vblank),
      .proc_done    (proc_done),
      .cap_en       (cap_en),
      .wr_buf_sel   (wr_buf_sel),
      .disp_buf_sel (disp_buf_sel),
      .proc_start   (proc_start),
      .proc_buf_sel (proc_buf_sel),
      .proc_ack     (proc_ack),
      .frame_count  (frame_count),
      .drop_count   (drop_count),
      .timeout_err  (timeout_err),
      .busy         (busy),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
      end
   endtask

   task automatic pulse_vblank();
      disp_vblank = 1'b1;
      tick(1);
      disp_vblank = 1'b0;
   endtask

   task automatic pulse_trigger();
      trigger = 1'b1;
      tick(1);
      trigger = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, " cap_en"}, 32'(cap_en), 0);
      check_output({tag, " wr_buf_sel"}, 32'(wr_buf_sel), 1);
      check_output({tag, " disp_buf_sel"}, 32'(disp_buf_sel), 0);
      check_output({tag, " proc_buf_sel"}, 32'(proc_buf_sel), 0);
      check_output({tag, " proc_start"}, 32'(proc_start), 0);
      check_output({tag, " proc_ack"}, 32'(proc_ack), 0);
      check_output({tag, " frame_count"}, 32'(frame_count), 0);
      check_output({tag, " drop_count"}, 32'(drop_count), 0);
      check_output({tag, " timeout_err"}, 32'(timeout_err), 0);
      check_output({tag, " busy"}, 32'(busy), 0);
      check_output({tag, " state"}, 32'(state_dbg), 0);
   endtask

   task automatic do_reset(input logic [1:0] m);
      reset = 1'b0;
      mode  = m;
      tick(2);
      reset = 1'b1;
      tick(3);
   endtask

   // One camera frame; returns at the negedge where the frame-end pulse is visible.
   task automatic apply_stimulus(input logic [1:0] exp_wr, input string tag);
      cam_vs = 1'b0;
      tick(3);
      check_output({tag, " cap_en before start+4"}, 32'(cap_en), 0);
      tick(1);
      check_output({tag, " cap_en at start+4"}, 32'(cap_en), 1);
      check_output({tag, " wr_buf_sel"}, 32'(wr_buf_sel), 32'(exp_wr));
      check_output({tag, " capture state"}, 32'(state_dbg), 2);
      tick(20);
      cam_vs = 1'b1;
      tick(2);
      check_output({tag, " cap_en at end+2"}, 32'(cap_en), 1);
      tick(1);
      check_output({tag, " cap_en at end+3"}, 32'(cap_en), 0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 2'd1, 2'd0, 0, 0};
      vecs[1] = '{1'b0, 2'd2, 2'd0, 0, 1};
      vecs[2] = '{1'b1, 2'd1, 2'd1, 1, 2};
      vecs[3] = '{1'b1, 2'd0, 2'd0, 2, 2};
      vecs[4] = '{1'b0, 2'd1, 2'd0, 2, 2};
      vecs[5] = '{1'b1, 2'd2, 2'd2, 3, 3};
      vecs[6] = '{1'b1, 2'd0, 2'd0, 4, 3};

      reset = 1'b0; mode = 2'd0; trigger = 1'b0; cam_vs = 1'b1;
      disp_vblank = 1'b0; proc_done = 1'b0;
      tick(3);
      check_reset_state("reset");
      reset = 1'b1;
      tick(3);

      // Continuous mode, buffer rotation with and without display swaps.
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(vecs[i].exp_wr, $sformatf("vec%0d", i));
         tick(8);
         if (vecs[i].vb) pulse_vblank();
         tick(2);
         check_output($sformatf("vec%0d disp_buf_sel", i), 32'(disp_buf_sel), 32'(vecs[i].exp_disp));
         check_output($sformatf("vec%0d frame_count", i), 32'(frame_count), 32'(vecs[i].exp_fc));
         check_output($sformatf("vec%0d drop_count", i), 32'(drop_count), 32'(vecs[i].exp_dc));
      end

      // COMMIT coinciding with vblank: old pending buffer goes to display.
      apply_stimulus(2'd1, "coinA");
      tick(8);
      apply_stimulus(2'd2, "coinB");
      tick(1);
      check_output("coin commit state", 32'(state_dbg), 4);
      pulse_vblank();
      check_output("coin disp old pend", 32'(disp_buf_sel), 1);
      check_output("coin frame_count", 32'(frame_count), 5);
      check_output("coin drop_count", 32'(drop_count), 3);
      tick(3);
      pulse_vblank();
      check_output("coin next vblank disp", 32'(disp_buf_sel), 2);
      check_output("coin next frame_count", 32'(frame_count), 6);

      // Asynchronous reset in the middle of a capture.
      tick(3);
      cam_vs = 1'b0;
      tick(4);
      check_output("rstcap cap_en before reset", 32'(cap_en), 1);
      tick(3);
      #2 reset = 1'b0;
      #1 check_output("rstcap cap_en async drop", 32'(cap_en), 0);
      check_reset_state("rstcap");
      cam_vs = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(5);
      apply_stimulus(2'd1, "postrst");
      tick(8);
      pulse_vblank();
      tick(2);
      check_output("postrst disp_buf_sel", 32'(disp_buf_sel), 1);
      check_output("postrst frame_count", 32'(frame_count), 1);

      // Single-shot with processing.
      do_reset(2'd3);
      check_output("ssproc idle state", 32'(state_dbg), 0);
      check_output("ssproc idle busy", 32'(busy), 0);
      pulse_trigger();
      check_output("ssproc armed", 32'(state_dbg), 1);
      apply_stimulus(2'd1, "ssproc");
      tick(1);
      check_output("ssproc proc state", 32'(state_dbg), 3);
      check_output("ssproc proc_start", 32'(proc_start), 1);
      check_output("ssproc proc_buf_sel", 32'(proc_buf_sel), 1);
      tick(19);
      check_output("ssproc proc_start held", 32'(proc_start), 1);
      proc_done = 1'b1;
      tick(1);
      check_output("ssproc proc_ack high", 32'(proc_ack), 1);
      check_output("ssproc proc_start fall", 32'(proc_start), 0);
      check_output("ssproc commit state", 32'(state_dbg), 4);
      proc_done = 1'b0;
      tick(1);
      check_output("ssproc proc_ack one cycle", 32'(proc_ack), 0);
      check_output("ssproc back idle", 32'(state_dbg), 0);
      check_output("ssproc busy low", 32'(busy), 0);
      pulse_vblank();
      tick(1);
      check_output("ssproc disp after vblank", 32'(disp_buf_sel), 1);
      check_output("ssproc frame_count", 32'(frame_count), 1);

      // Single-shot timeout with VSYNC stuck low.
      do_reset(2'd1);
      pulse_trigger();
      cam_vs = 1'b0;
      tick(4);
      check_output("tmo cap_en open", 32'(cap_en), 1);
      tick(999);
      check_output("tmo not yet", 32'(timeout_err), 0);
      check_output("tmo cap_en still", 32'(cap_en), 1);
      tick(1);
      check_output("tmo timeout_err", 32'(timeout_err), 1);
      check_output("tmo cap_en closed", 32'(cap_en), 0);
      check_output("tmo idle", 32'(state_dbg), 0);
      pulse_vblank();
      tick(1);
      check_output("tmo no commit frames", 32'(frame_count), 0);
      check_output("tmo no commit disp", 32'(disp_buf_sel), 0);
      pulse_trigger();
      check_output("tmo trigger clears", 32'(timeout_err), 0);
      check_output("tmo trigger arms", 32'(state_dbg), 1);
      cam_vs = 1'b1;
      tick(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
